// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared constants for the seven-segment display blocks.
//
// Contents:
//   SEG_BLANK  : all eight segments (including DP) dark, active-low.
//   SEG_OFF    : a..g dark, DP excluded.
//   DP_BIT     : position of the decimal point in the 8-bit segment byte.
//   SEG_TABLE  : active-low a..g pattern per hex nibble (a = bit 6, g = bit 0).
// ---------------------------------------------------------------------------
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [6:0] SEG_OFF   = 7'h7F;
   localparam int         DP_BIT    = 7;

   // Entry n is the pattern for nibble n; listed from F down to 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
      7'h60, 7'h08, 7'h04, 7'h00,   // b A 9 8
      7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
      7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
   };

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode -- combinational hex nibble to active-low a..g segments.
//
// Ports:
//   nibble  in  4  hex digit to show
//   seg     out 7  active-low segments, a = bit 6 ... g = bit 0
// ---------------------------------------------------------------------------
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seghex_scan.sv
// ---------------------------------------------------------------------------
// seghex_scan -- time-multiplexed driver for DIGITS seven-segment digits.
//
// Each digit is selected for DIV clocks in turn (digit 0 first). The value and
// decimal-point inputs are snapshotted at the start of every frame so one
// frame never mixes old and new data.
//
// Parameters:
//   DIGITS         number of digits scanned (1..16)
//   DIV            clocks each digit stays selected (>= 2)
//   AN_ACTIVE_LOW  1: selected anode drives 0; 0: selected anode drives 1
//
// Ports:
//   clk    in  1          system clock
//   rst    in  1          asynchronous active-high reset
//   en     in  1          display enable; low blanks outputs and freezes scan
//   value  in  4*DIGITS   hex nibbles, digit k = value[4k+3:4k]
//   dp     in  DIGITS     decimal point per digit, 1 = lit
//   hex    out 8          registered active-low segments, bit 7 = DP
//   an     out DIGITS     registered digit selects
//   frame  out 1          one-cycle pulse when the scan returns to digit 0
//
// Build option:
//   LEADING_ZERO_BLANK_EN  blank digits k > 0 whose nibble and all higher
//                          nibbles are zero (DP still shown).
// ---------------------------------------------------------------------------
module seghex_scan
   import seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int DIV           = 50000,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   output logic [7:0]            hex,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PCNT_W = $clog2(DIV);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(DIV - 1);
   localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{(AN_ACTIVE_LOW != 0)}};

   logic [PCNT_W-1:0]   pcnt, pcnt_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [4*DIGITS-1:0] vshadow, vsh_nxt;
   logic [DIGITS-1:0]   dpshadow, dpsh_nxt;
   logic                primed;     // first capture after reset has happened

   logic                run, tick, wrap, capture;
   logic [3:0]          sel_nib;
   logic [6:0]          dec_seg;
   logic                blank_sel;
   logic [7:0]          hex_nxt;
   logic [DIGITS-1:0]   an_nxt;

   // The capture edge after reset only loads the snapshot and shows digit 0;
   // counting starts on the following edge so digit 0 gets a full DIV cycles.
   assign run     = en & primed;
   assign tick    = run & (pcnt == LAST_PCNT);
   assign wrap    = tick & (idx == LAST_IDX);
   assign capture = en & (~primed | wrap);

   always_comb begin
      // NOTE: every output of an always_comb gets a default first, so no
      // path through the block can leave it unassigned and infer a latch.
      pcnt_nxt = pcnt;
      idx_nxt  = idx;
      vsh_nxt  = vshadow;
      dpsh_nxt = dpshadow;
      if (run) begin
         pcnt_nxt = tick ? '0 : pcnt + 1'b1;
         if (wrap)
            idx_nxt = '0;
         else if (tick)
            idx_nxt = idx + 1'b1;
      end
      if (capture) begin
         vsh_nxt  = value;
         dpsh_nxt = dp;
      end
   end

   // Outputs are decoded from the post-edge index and snapshot so the new
   // frame's digit 0 appears on the same edge the snapshot is taken.
   assign sel_nib = vsh_nxt[{idx_nxt, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble (sel_nib),
      .seg    (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_mask;

   // Sweep from the top digit down; a digit is blank while every nibble from
   // it upward is zero. Digit 0 is never blanked.
   always_comb begin
      logic zero_above;
      blank_mask = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_above    = zero_above & (vsh_nxt[4*k +: 4] == 4'h0);
         blank_mask[k] = zero_above;
      end
   end

   assign blank_sel = blank_mask[idx_nxt];
`else
   assign blank_sel = 1'b0;
`endif

   always_comb begin
      hex_nxt = SEG_BLANK;
      an_nxt  = AN_OFF;
      if (en) begin
         hex_nxt[DP_BIT] = ~dpsh_nxt[idx_nxt];
         hex_nxt[6:0]    = blank_sel ? SEG_OFF : dec_seg;
         an_nxt          = AN_OFF ^ (DIGITS'(1) << idx_nxt);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the shadow registers are reset too; they feed the outputs
         // and must hold a known snapshot before the first capture.
         pcnt     <= '0;
         idx      <= '0;
         vshadow  <= '0;
         dpshadow <= '0;
         primed   <= 1'b0;
         hex      <= SEG_BLANK;
         an       <= AN_OFF;
         frame    <= 1'b0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         pcnt     <= pcnt_nxt;
         idx      <= idx_nxt;
         vshadow  <= vsh_nxt;
         dpshadow <= dpsh_nxt;
         primed   <= primed | en;
         hex      <= hex_nxt;
         an       <= an_nxt;
         frame    <= wrap;
      end
   end

endmodule

// File: tb/tb_seghex_scan.sv
// ---------------------------------------------------------------------------
// tb_seghex_scan -- self-checking bench for seghex_scan (DIGITS=4, DIV=4,
// active-low anodes). The reference model tracks the number of enabled clocks
// since the first capture and derives digit, frame and snapshot from it.
// ---------------------------------------------------------------------------
module tb_seghex_scan;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int FRAME  = DIGITS * DIV;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp;
   logic [7:0]          hex;
   logic [DIGITS-1:0]   an;
   logic                frame;

   always #5 clk = ~clk;

   seghex_scan #(
      .DIGITS        (DIGITS),
      .DIV           (DIV),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .value (value),
      .dp    (dp),
      .hex   (hex),
      .an    (an),
      .frame (frame)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Segment bytes for nibbles 0..F with DP off.
   logic [7:0] seg_ref [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                                8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};

   // Reference model state.
   bit          m_primed;
   int          m_cnt;
   logic [15:0] m_snap;
   logic [3:0]  m_dps;
   int          m_digit;
   logic [7:0]  e_hex;
   logic [3:0]  e_an;
   logic        e_frame;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] expect_seg(input logic [15:0] snap, input logic [3:0] dps,
                                             input int d);
      logic [15:0] s16;
      logic [3:0]  nib;
      logic [7:0]  s;
      s16 = snap >> (4 * d);
      nib = s16[3:0];
      s   = seg_ref[nib];
      s[7] = ~dps[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && s16 == 16'h0000)
         s[6:0] = 7'h7F;
`endif
      return s;
   endfunction

   task automatic model_reset();
      m_primed = 1'b0;
      m_cnt    = 0;
      m_snap   = '0;
      m_dps    = '0;
      e_hex    = 8'hFF;
      e_an     = 4'hF;
      e_frame  = 1'b0;
   endtask

   // One clock: update the model from the inputs present at the edge, then
   // compare all outputs 1 time unit after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (en) begin
         e_frame = 1'b0;
         if (!m_primed) begin
            m_primed = 1'b1;
            m_cnt    = 0;
            m_snap   = value;
            m_dps    = dp;
         end else begin
            m_cnt++;
            if (m_cnt % FRAME == 0) begin
               e_frame = 1'b1;
               m_snap  = value;
               m_dps   = dp;
            end
         end
         m_digit = (m_cnt / DIV) % DIGITS;
         e_hex   = expect_seg(m_snap, m_dps, m_digit);
         e_an    = ~(4'(1) << m_digit);
      end else begin
         e_hex   = 8'hFF;
         e_an    = 4'hF;
         e_frame = 1'b0;
      end
      #1;
      check({tag, ".hex"},   16'(hex),   16'(e_hex));
      check({tag, ".an"},    16'(an),    16'(e_an));
      check({tag, ".frame"}, 16'(frame), 16'(e_frame));
   endtask

   // Assert reset between edges and check that outputs clear without a clock.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      check({tag, ".hex"},   16'(hex),   16'h00FF);
      check({tag, ".an"},    16'(an),    16'h000F);
      check({tag, ".frame"}, 16'(frame), 16'h0000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      value = 16'h1234;
      dp    = 4'b0000;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst.hex",   16'(hex),   16'h00FF);
      check("rst.an",    16'(an),    16'h000F);
      check("rst.frame", 16'(frame), 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // First edge after release shows digit 0 of 1234.
      step("start");
      check("first.hex", 16'(hex), 16'h00CC);
      check("first.an",  16'(an),  16'h000E);

      // Scan 1234 into the second frame, reaching digit 2 (count 24).
      repeat (24) step("scan");

      // Change value mid-frame; digit 3 of this frame still shows 1.
      value = 16'hABCD;
      repeat (4) step("snap");
      check("snap.d3", 16'(hex), 16'h00CF);
      repeat (4) step("snap");
      check("snap.d0",    16'(hex),   16'h00C2);
      check("snap.frame", 16'(frame), 16'h0001);

      // Decimal point on digit 1, captured at the next frame start.
      dp = 4'b0010;
      repeat (20) step("dp");
      check("dp.d1", 16'(hex), 16'h0031);

      // Freeze at digit 2 for 10 cycles, then resume on the same digit.
      repeat (5) step("pre_off");
      en = 1'b0;
      repeat (10) step("en_off");
      check("off.hex", 16'(hex), 16'h00FF);
      check("off.an",  16'(an),  16'h000F);
      en = 1'b1;
      step("resume");
      check("resume.an", 16'(an), 16'h000B);
      repeat (6) step("resume");

      // Mid-scan asynchronous reset and fresh start.
      do_reset("midrst");
      dp    = 4'b0000;
      value = 16'h0050;
      repeat (40) step("lz50");
      value = 16'h0000;
      repeat (40) step("lz0");

      // Randomized enable, data and occasional reset.
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2)
            do_reset("rnd_rst");
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0)
               value = 16'($urandom);
            else
               value = 16'($urandom_range(0, 255));
            dp = 4'($urandom);
         end
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
